// File: rtl/mac_dump.sv
// Integrate-and-dump after the DSP multiplier: sums DECIM products, shifts, saturates; 2-edge latency, never stalls upstream.
// A result that finds the output register full is dropped and flags overrun; MAC_DUMP_ROUND_EN selects round-half-up instead of floor.
module mac_dump #(
    parameter int IN_W  = 36,
    parameter int ACC_W = 48,
    parameter int OUT_W = 18,
    parameter int DECIM = 16,
    parameter int SHIFT = 30
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic signed [IN_W-1:0]  in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [OUT_W-1:0] out_data,
    output logic                    sat,
    output logic                    overrun,
    input  logic                    clr
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DECIM - 1);

    localparam logic signed [ACC_W:0] MAXV = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] MINV = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    generate
        if (ACC_W < IN_W + $clog2(DECIM)) begin : g_acc_too_narrow
            $error("mac_dump: ACC_W must be >= IN_W + clog2(DECIM)");
        end
        if (DECIM < 1 || DECIM > 65535) begin : g_bad_decim
            $error("mac_dump: DECIM out of range 1..65535");
        end
        if (SHIFT < 0 || SHIFT >= ACC_W) begin : g_bad_shift
            $error("mac_dump: SHIFT out of range 0..ACC_W-1");
        end
    endgenerate

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] in_ext;
    logic signed [ACC_W-1:0] sum;
    logic        [CNT_W-1:0] cnt;
    logic signed [ACC_W-1:0] dump_reg;
    logic                    dump_v;

    assign in_ext = ACC_W'(in_data);
    assign sum    = acc + in_ext;

    always_ff @(posedge clk) begin
        if (rst) begin
            acc      <= '0;
            cnt      <= '0;
            dump_reg <= '0;
            dump_v   <= 1'b0;
        end else begin
            dump_v <= 1'b0;
            if (in_valid) begin
                if (cnt == LAST) begin
                    dump_reg <= sum;
                    dump_v   <= 1'b1;
                    acc      <= '0;
                    cnt      <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    // One extra bit of headroom so the rounding offset can never wrap.
    logic signed [ACC_W:0] dump_ext;
    logic signed [ACC_W:0] pre_shift;
    logic signed [ACC_W:0] scaled;
    logic                  clamp_hi;
    logic                  clamp_lo;
    logic signed [OUT_W-1:0] sample;

    assign dump_ext = {dump_reg[ACC_W-1], dump_reg};

`ifdef MAC_DUMP_ROUND_EN
    localparam logic signed [ACC_W:0] RND = ((ACC_W+1)'(1) << SHIFT) >> 1;
    assign pre_shift = dump_ext + RND;
`else
    assign pre_shift = dump_ext;
`endif

    assign scaled   = pre_shift >>> SHIFT;
    assign clamp_hi = scaled > MAXV;
    assign clamp_lo = scaled < MINV;
    assign sample   = clamp_hi ? MAXV[OUT_W-1:0] :
                      clamp_lo ? MINV[OUT_W-1:0] : scaled[OUT_W-1:0];

    logic load;
    logic drop;

    assign load = dump_v && (!out_valid || out_ready);
    assign drop = dump_v && out_valid && !out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            sat       <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (load) begin
                out_data  <= sample;
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
            // A set event in the same cycle as clr takes priority.
            sat     <= (sat && !clr) || (dump_v && (clamp_hi || clamp_lo));
            overrun <= (overrun && !clr) || drop;
        end
    end

endmodule

// File: tb/tb_mac_dump.sv
// Bench for mac_dump: two instances (SHIFT 0 and 2, DECIM 4) driven together, checked against a window-level model.
module tb_mac_dump;

    localparam int DEC = 4;
    localparam longint OMAX = 131071;
    localparam longint OMIN = -131072;

    logic               clk;
    logic               rst;
    logic               in_valid;
    logic        [35:0] in_data;
    logic               out_ready;
    logic               clr;
    logic               out_valid0, out_valid2;
    logic signed [17:0] out_data0, out_data2;
    logic               sat0, sat2, overrun0, overrun2;

    mac_dump #(.IN_W(36), .ACC_W(48), .OUT_W(18), .DECIM(DEC), .SHIFT(0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .sat(sat0), .overrun(overrun0), .clr(clr));

    mac_dump #(.IN_W(36), .ACC_W(48), .OUT_W(18), .DECIM(DEC), .SHIFT(2)) u_dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid2), .out_ready(out_ready), .out_data(out_data2),
        .sat(sat2), .overrun(overrun2), .clr(clr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Window-level reference: each completed window's sum becomes visible one edge later.
    int     sh[2] = '{0, 2};
    longint wsum;
    int     beats;
    bit     pend_v;
    longint pend_sum;
    bit     m_valid[2];
    longint m_data[2];
    bit     m_sat[2];
    bit     m_ovr[2];

    function automatic longint scale(input longint s, input int k);
`ifdef MAC_DUMP_ROUND_EN
        if (k > 0) return (s + (longint'(1) <<< (k - 1))) >>> k;
        return s;
`else
        return s >>> k;
`endif
    endfunction

    task automatic model_edge(input bit r, input bit iv, input longint d, input bit rdy, input bit c);
        longint v;
        bit     set_sat;
        bit     set_ovr;
        if (r) begin
            wsum = 0; beats = 0; pend_v = 0; pend_sum = 0;
            for (int i = 0; i < 2; i++) begin
                m_valid[i] = 0; m_data[i] = 0; m_sat[i] = 0; m_ovr[i] = 0;
            end
            return;
        end
        for (int i = 0; i < 2; i++) begin
            set_sat = 0;
            set_ovr = 0;
            if (pend_v) begin
                v = scale(pend_sum, sh[i]);
                if (v > OMAX) begin v = OMAX; set_sat = 1; end
                else if (v < OMIN) begin v = OMIN; set_sat = 1; end
                if (!m_valid[i] || rdy) begin
                    m_valid[i] = 1;
                    m_data[i]  = v;
                end else begin
                    set_ovr = 1;
                end
            end else if (m_valid[i] && rdy) begin
                m_valid[i] = 0;
            end
            m_sat[i] = (m_sat[i] && !c) || set_sat;
            m_ovr[i] = (m_ovr[i] && !c) || set_ovr;
        end
        pend_v = 0;
        if (iv) begin
            wsum += d;
            beats++;
            if (beats == DEC) begin
                pend_v   = 1;
                pend_sum = wsum;
                wsum     = 0;
                beats    = 0;
            end
        end
    endtask

    task automatic compare_all();
        chk("valid0", out_valid0, m_valid[0]);
        chk("data0", out_data0, m_data[0]);
        chk("sat0", sat0, m_sat[0]);
        chk("ovr0", overrun0, m_ovr[0]);
        chk("valid2", out_valid2, m_valid[1]);
        chk("data2", out_data2, m_data[1]);
        chk("sat2", sat2, m_sat[1]);
        chk("ovr2", overrun2, m_ovr[1]);
    endtask

    task automatic step(input bit r, input bit iv, input longint d, input bit rdy, input bit c);
        rst       = r;
        in_valid  = iv;
        in_data   = d[35:0];
        out_ready = rdy;
        clr       = c;
        @(posedge clk);
        model_edge(r, iv, d, rdy, c);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(0, 0, 0, rdy, 0);
    endtask

    task automatic window(input longint a, input longint b, input longint c, input longint d, input bit rdy);
        step(0, 1, a, rdy, 0);
        step(0, 1, b, rdy, 0);
        step(0, 1, c, rdy, 0);
        step(0, 1, d, rdy, 0);
    endtask

    initial begin
        logic [63:0] t;
        longint      d;
        bit          iv, rdy, c, r;

        rst = 1; in_valid = 0; in_data = '0; out_ready = 1; clr = 0;

        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        chk("rst_valid", out_valid0, 0);
        chk("rst_data", out_data0, 0);
        chk("rst_flags", {sat0, overrun0}, 0);

        window(1, 2, 3, 4, 1);
        chk("lat_early", out_valid0, 0);
        idle(1, 1);
        chk("lat_valid", out_valid0, 1);
        chk("sum10", out_data0, 10);
        chk("sum10_sat", sat0, 0);
        idle(1, 1);
        chk("one_cycle", out_valid0, 0);

        window(100000, 100000, 100000, 100000, 1);
        idle(2, 1);
        chk("clamp_max", out_data0, OMAX);
        chk("clamp_sat", sat0, 1);
        window(-100000, -100000, -100000, -100000, 1);
        idle(2, 1);
        chk("clamp_min", out_data0, OMIN);
        step(0, 0, 0, 1, 1);
        chk("clr_sat", sat0, 0);

        window(1, 2, 3, 0, 1);
        idle(2, 1);
`ifdef MAC_DUMP_ROUND_EN
        chk("shift_pos", out_data2, 2);
`else
        chk("shift_pos", out_data2, 1);
`endif
        window(-1, -2, -3, 0, 1);
        idle(2, 1);
`ifdef MAC_DUMP_ROUND_EN
        chk("shift_neg", out_data2, -1);
`else
        chk("shift_neg", out_data2, -2);
`endif

        window(1, 1, 1, 1, 0);
        window(2, 2, 2, 2, 0);
        idle(2, 0);
        chk("hold_data", out_data0, 4);
        chk("hold_valid", out_valid0, 1);
        chk("overrun", overrun0, 1);
        idle(1, 1);
        chk("drain", out_valid0, 0);
        step(0, 0, 0, 1, 1);
        chk("clr_ovr", overrun0, 0);

        step(0, 1, 1, 1, 0);
        step(0, 1, 1, 1, 0);
        step(1, 0, 0, 1, 0);
        window(1, 1, 1, 1, 1);
        idle(2, 1);
        chk("rst_mid", out_data0, 4);

        for (int v = 1; v <= 4; v++) begin
            step(0, 1, v, 1, 0);
            step(0, 0, 0, 1, 0);
        end
        chk("gap_valid", out_valid0, 1);
        chk("gap_data", out_data0, 10);
        idle(1, 1);

        for (int i = 0; i < 600; i++) begin
            iv  = ($urandom_range(0, 3) != 0);
            rdy = ($urandom_range(0, 9) < 7);
            c   = ($urandom_range(0, 19) == 0);
            r   = ($urandom_range(0, 249) == 0);
            if ($urandom_range(0, 2) == 0) begin
                t = {$urandom(), $urandom()};
                d = longint'($signed(t[35:0]));
            end else begin
                d = longint'($urandom_range(0, 200000)) - 100000;
            end
            step(r, iv, d, rdy, c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
